// File: rtl/alu_pkg.sv
// Shared definitions for the button/switch ALU and its front-end sequencer:
// op-code constants, sequencer state encodings and the op-code validity check.
package alu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

    localparam logic [1:0] ST_WAIT_A  = 2'd0;
    localparam logic [1:0] ST_WAIT_B  = 2'd1;
    localparam logic [1:0] ST_WAIT_OP = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef struct packed {
        logic a;
        logic b;
        logic op;
    } btn_set_t;

    function automatic logic is_valid_op(input logic [OP_W-1:0] code);
        case (code)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, debounce counter on the synchronized
// level, and a one-cycle pulse on each rising edge of the accepted (stable) level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic             r_stable_q;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta     <= 1'b0;
            r_sync     <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_q <= 1'b0;
            r_press    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_meta     <= i_btn;
            r_sync     <= r_meta;
            r_stable_q <= r_stable;
            r_press    <= r_stable & ~r_stable_q;
            // Any sample matching the accepted level restarts the count, so glitches vanish.
            if (r_sync != r_stable) begin
                if (r_cnt == CNT_LAST) begin
                    r_stable <= r_sync;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/alu_btn_sequencer.sv
// Front-end controller for the button/switch ALU: enforces the A -> B -> OP load
// order, strobes the ALU with a switch snapshot and captures its result for the LEDs.
module alu_btn_sequencer
    import alu_pkg::*;
#(
    parameter int OPERAND_SIZE    = 8,
    parameter int OP_CODE_SIZE    = 6,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [OPERAND_SIZE-1:0] i_switches,
    input  logic                    i_btn_A,
    input  logic                    i_btn_B,
    input  logic                    i_btn_OP,
    input  logic [OPERAND_SIZE-1:0] i_alu_result,
    output logic [OPERAND_SIZE-1:0] o_data,
    output logic                    o_load_a,
    output logic                    o_load_b,
    output logic                    o_load_op,
    output logic [OPERAND_SIZE-1:0] o_result,
    output logic                    o_result_valid,
    output logic [1:0]              o_state,
    output logic                    o_error
);

    logic                    w_press_a;
    logic                    w_press_b;
    logic                    w_press_op;
    btn_set_t                w_sel;
    logic [OP_W-1:0]         w_op_code;
    logic                    w_op_ok;
    logic [1:0]              w_next_state;
    logic                    w_stb_a;
    logic                    w_stb_b;
    logic                    w_stb_op;
    logic                    w_reject;
    logic                    w_cap_req;
    logic                    w_any_stb;

    logic [OPERAND_SIZE-1:0] r_sw_meta;
    logic [OPERAND_SIZE-1:0] r_sw_sync;
    logic [1:0]              r_state;
    logic                    r_load_a;
    logic                    r_load_b;
    logic                    r_load_op;
    logic [OPERAND_SIZE-1:0] r_data;
    logic                    r_error;
    logic                    r_cap_req;
    logic                    r_cap_arm;
    logic [OPERAND_SIZE-1:0] r_result;
    logic                    r_valid;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_A),
        .o_press (w_press_a)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_B),
        .o_press (w_press_b)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_OP),
        .o_press (w_press_op)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= i_switches;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign w_op_code = OP_W'(r_sw_sync[OP_CODE_SIZE-1:0]);
    assign w_op_ok   = is_valid_op(w_op_code);

    // Same-cycle presses resolve A > B > OP; the losers are simply discarded.
    always_comb begin
        w_sel.a  = w_press_a;
        w_sel.b  = w_press_b & ~w_press_a;
        w_sel.op = w_press_op & ~w_press_a & ~w_press_b;
    end

    always_comb begin
        w_next_state = r_state;
        w_stb_a      = 1'b0;
        w_stb_b      = 1'b0;
        w_stb_op     = 1'b0;
        w_reject     = 1'b0;
        w_cap_req    = 1'b0;
        case (r_state)
            ST_WAIT_A: begin
                if (w_sel.a) begin
                    w_stb_a      = 1'b1;
                    w_next_state = ST_WAIT_B;
                end else if (w_sel.b || w_sel.op) begin
                    w_reject = 1'b1;
                end
            end
            ST_WAIT_B: begin
                if (w_sel.a) begin
                    w_stb_a = 1'b1;
                end else if (w_sel.b) begin
                    w_stb_b      = 1'b1;
                    w_next_state = ST_WAIT_OP;
                end else if (w_sel.op) begin
                    w_reject = 1'b1;
                end
            end
            ST_WAIT_OP: begin
                if (w_sel.a) begin
                    w_stb_a      = 1'b1;
                    w_next_state = ST_WAIT_B;
                end else if (w_sel.b) begin
                    w_stb_b = 1'b1;
                end else if (w_sel.op) begin
                    if (w_op_ok) begin
                        w_stb_op     = 1'b1;
                        w_cap_req    = 1'b1;
                        w_next_state = ST_DONE;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            default: begin
                if (w_sel.a) begin
                    w_stb_a      = 1'b1;
                    w_next_state = ST_WAIT_B;
                end else if (w_sel.b) begin
                    w_stb_b   = 1'b1;
                    w_cap_req = 1'b1;
                end else if (w_sel.op) begin
                    if (w_op_ok) begin
                        w_stb_op  = 1'b1;
                        w_cap_req = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
        endcase
    end

    assign w_any_stb = w_stb_a | w_stb_b | w_stb_op;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_WAIT_A;
            r_load_a  <= 1'b0;
            r_load_b  <= 1'b0;
            r_load_op <= 1'b0;
            r_data    <= '0;
            r_error   <= 1'b0;
            r_cap_req <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_load_a  <= w_stb_a;
            r_load_b  <= w_stb_b;
            r_load_op <= w_stb_op;
            r_cap_req <= w_cap_req;
            if (w_any_stb) begin
                r_data  <= r_sw_sync;
                r_error <= 1'b0;
            end else if (w_reject) begin
                r_error <= 1'b1;
            end
        end
    end

    // The ALU registers load at the end of the strobe cycle, so its output is
    // sampled one cycle later; a newer strobe always replaces a pending capture.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cap_arm <= 1'b0;
            r_result  <= '0;
            r_valid   <= 1'b0;
        end else if (r_load_a || r_load_b || r_load_op) begin
            r_valid   <= 1'b0;
            r_cap_arm <= r_cap_req;
        end else if (r_cap_arm) begin
            r_result  <= i_alu_result;
            r_valid   <= 1'b1;
            r_cap_arm <= 1'b0;
        end
    end

    assign o_data         = r_data;
    assign o_load_a       = r_load_a;
    assign o_load_b       = r_load_b;
    assign o_load_op      = r_load_op;
    assign o_result       = r_result;
    assign o_result_valid = r_valid;
    assign o_state        = r_state;
    assign o_error        = r_error;

endmodule

// File: doc/alu_btn_sequencer.md
# alu_btn_sequencer

Front-end controller for the 8-bit button/switch ALU. It synchronizes and debounces the three raw pushbuttons and enforces the load order A → B → OP. It drives the ALU with a registered switch snapshot and one-cycle load strobes, then captures the ALU result into a stable, flagged output register for the LEDs. It sits between the board I/O and the ALU; the ALU's switch and button inputs are fed only from this block.

## Interface
- `OPERAND_SIZE`, 8, operand and result width
- `OP_CODE_SIZE`, 6, op-code width (low bits of the switch bus)
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable cycles required before a button level is accepted (≥2)

Ports:
- `i_clk`, in, 1, system clock
- `i_reset`, in, 1, asynchronous, active-high reset
- `i_switches`, in, OPERAND_SIZE, raw board switches
- `i_btn_A` / `i_btn_B` / `i_btn_OP`, in, 1 each, raw asynchronous pushbuttons
- `i_alu_result`, in, OPERAND_SIZE, combinational ALU result
- `o_data`, out, OPERAND_SIZE, registered switch snapshot to the ALU switch input
- `o_load_a` / `o_load_b` / `o_load_op`, out, 1 each, one-cycle load strobes to the ALU
- `o_result`, out, OPERAND_SIZE, captured result
- `o_result_valid`, out, 1, `o_result` is the result of the current A/B/OP
- `o_state`, out, 2, FSM state for the LEDs
- `o_error`, out, 1, a press was rejected

## Operation
- **Per-button conditioning:**
  - 2-FF synchronizer, then the debounce counter.
  - The stable level changes only after `DEBOUNCE_CYCLES` consecutive samples differ from it.
  - A rising edge of the stable level gives a one-cycle press pulse.
  - `i_switches` passes through its own 2-FF synchronizer and is not debounced.
- **Same-cycle presses:** priority A > B > OP. Lower-priority pulses in that cycle are dropped silently, with no error.
- **FSM states:** WAIT_A=0, WAIT_B=1, WAIT_OP=2, DONE=3.
  - WAIT_A: A press → strobe A, go to WAIT_B. B or OP press → set `o_error`, no state change.
  - WAIT_B: B press → strobe B, go to WAIT_OP. A press → strobe A, stay (reload). OP press → error.
  - WAIT_OP: OP press with a valid code → strobe OP, go to DONE. OP press with an invalid code → error, stay. A press → strobe A, go to WAIT_B. B press → strobe B, stay.
  - DONE: A press → strobe A, clear valid, go to WAIT_B. B press, or OP press with a valid code → strobe, clear valid, recapture, stay in DONE. OP press with an invalid code → error; valid and result are held.
- **Valid op codes:** 100000, 100010, 100100, 100101, 100110, 000011, 000010, 100111. Any other value of `i_switches[OP_CODE_SIZE-1:0]` is invalid.
- **`o_data`:** on every strobe cycle, `o_data` holds the synchronized switch value sampled in the press-pulse cycle. It holds its value otherwise.
- **`o_error`:** sticky; cleared by the next accepted strobe.
- **Result width:** `o_result` is captured as-is at OPERAND_SIZE. No extension or saturation.

## Timing
- **Reset:** all outputs are 0, state is WAIT_A, stable levels and counters are 0. Assertion mid-operation aborts immediately.
- **Button held through reset release:** treated as a fresh press; its strobe follows the normal latency after release.
- **Press latency:** raw high first sampled at edge 0 → press pulse high after edge `DEBOUNCE_CYCLES+2` → strobe high after edge `DEBOUNCE_CYCLES+3`, for exactly one cycle.
- **Release:** requires `DEBOUNCE_CYCLES` stable-low samples before another press can register. Glitches shorter than `DEBOUNCE_CYCLES` produce nothing.
- **Result capture:**
  - Strobe in cycle T; the ALU registers update at the end of T.
  - `i_alu_result` is sampled at the end of T+1.
  - `o_result_valid` is high from T+2.
  - Valid drops in the cycle after any A or B strobe, or after a valid OP strobe, and stays low until the recapture.
- **Back-to-back presses:** a pending capture is superseded by a newer strobe; only the last capture is reported.
- **`o_state`:** registered, same cycle as the state transition.

## Structure
- Shared package `alu_pkg`: the eight op-code constants, FSM state encodings, and the function `is_valid_op()`. The ALU and this block both use it.
- Sub-module `btn_debounce`: synchronizer, debounce counter, and edge pulse, parameterized by `DEBOUNCE_CYCLES`. Instantiated three times.
- Top level: switch synchronizer, FSM, and the `o_data` / `o_result` registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
1. **Full sequence:** reset; switches=0x05, press A; 0x03, press B; 0x20, press OP → one strobe each, 7 edges after each press, in order. `o_result`=0x08 with valid high two cycles after the OP strobe; `o_state`=3.
2. **Out-of-order press:** press B first after reset → no strobe, `o_error`=1, `o_state`=0. Then press A → strobe A, `o_error`=0, `o_state`=1.
3. **Invalid op code:** in WAIT_OP, switches=0x3F, press OP → `o_error`=1, no strobe, state stays 2. Then switches=0x22 with A=0x05, B=0x03 → `o_result`=0x02.
4. **Bounce rejection:** A toggles 1,0,1,0 every 2 cycles, then holds high 10 cycles → exactly one `o_load_a` pulse, after the final hold.
5. **Simultaneous presses:** A and B pressed in the same cycle in WAIT_A → only `o_load_a` fires; state 1; no error. Then, in DONE, a B press with switches=0x01 → valid drops, then recaptures 0x06.
6. **Reset mid-operation:** assert `i_reset` two cycles after the B strobe → all outputs 0 immediately, `o_state`=0. A button held through release → one strobe 7 edges after release.
